// File: rtl/dram_wbl_write_seq.sv
// Row write sequencer for the DRAM CIM macro: precharge, then 16 column beats
// of setup/write/hold, ending with a one-cycle wr_done pulse.
module dram_wbl_write_seq #(
    parameter int T_PRE   = 2,
    parameter int T_SETUP = 1,
    parameter int T_WE    = 2,
    parameter int T_HOLD  = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        IO_EN,
    input  logic [5:0]  ADDR,
    input  logic [63:0] WBL_DATA1,
    input  logic [63:0] WBL_DATA2,
    input  logic [63:0] WBL_DATA3,
    input  logic [63:0] WBL_DATA4,
    input  logic [63:0] WBL_DATA5,
    input  logic [63:0] WBL_DATA6,
    input  logic [63:0] WBL_DATA7,
    input  logic [63:0] WBL_DATA8,
    input  logic [63:0] WBL_DATA9,
    input  logic [63:0] WBL_DATA10,
    input  logic [63:0] WBL_DATA11,
    input  logic [63:0] WBL_DATA12,
    input  logic [63:0] WBL_DATA13,
    input  logic [63:0] WBL_DATA14,
    input  logic [63:0] WBL_DATA15,
    input  logic [63:0] WBL_DATA16,
    output logic        wr_done,
    output logic        BUSY,
    output logic [5:0]  WL_ADDR,
    output logic        WL_EN,
    output logic        PRE,
    output logic [3:0]  COL_SEL,
    output logic [63:0] WBL,
    output logic        WE,
    output logic        ERR_OVERRUN
);

    localparam int M1   = (T_PRE > T_SETUP) ? T_PRE : T_SETUP;
    localparam int M2   = (T_WE > T_HOLD) ? T_WE : T_HOLD;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] L_PRE   = CW'(T_PRE - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_WE    = CW'(T_WE - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SETUP, S_WRITE, S_HOLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    beat_q, beat_d;
    logic [5:0]    addr_q, addr_d;
    logic [63:0]   data_q [16];
    logic [63:0]   data_d [16];
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          wl_en_q, wl_en_d;
    logic          pre_q, pre_d;
    logic          we_q, we_d;
    logic [3:0]    col_sel_q, col_sel_d;
    logic [63:0]   wbl_q, wbl_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q | (IO_EN && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (IO_EN) begin
                    state_d    = S_PRE;
                    cnt_d      = L_PRE;
                    beat_d     = 4'd0;
                    addr_d     = ADDR;
                    data_d[0]  = WBL_DATA1;
                    data_d[1]  = WBL_DATA2;
                    data_d[2]  = WBL_DATA3;
                    data_d[3]  = WBL_DATA4;
                    data_d[4]  = WBL_DATA5;
                    data_d[5]  = WBL_DATA6;
                    data_d[6]  = WBL_DATA7;
                    data_d[7]  = WBL_DATA8;
                    data_d[8]  = WBL_DATA9;
                    data_d[9]  = WBL_DATA10;
                    data_d[10] = WBL_DATA11;
                    data_d[11] = WBL_DATA12;
                    data_d[12] = WBL_DATA13;
                    data_d[13] = WBL_DATA14;
                    data_d[14] = WBL_DATA15;
                    data_d[15] = WBL_DATA16;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETUP;
                    cnt_d   = L_SETUP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_WRITE;
                    cnt_d   = L_WE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = L_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    if (beat_q == 4'd15) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = L_SETUP;
                        beat_d  = beat_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        pre_d     = (state_d == S_PRE);
        wl_en_d   = (state_d == S_SETUP) || (state_d == S_WRITE) || (state_d == S_HOLD);
        we_d      = (state_d == S_WRITE);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        col_sel_d = wl_en_d ? beat_d : 4'd0;
        wbl_d     = wl_en_d ? data_q[beat_d] : 64'd0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            beat_q    <= 4'd0;
            addr_q    <= 6'd0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wl_en_q   <= 1'b0;
            pre_q     <= 1'b0;
            we_q      <= 1'b0;
            col_sel_q <= 4'd0;
            wbl_q     <= 64'd0;
            for (int i = 0; i < 16; i++) data_q[i] <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            wl_en_q   <= wl_en_d;
            pre_q     <= pre_d;
            we_q      <= we_d;
            col_sel_q <= col_sel_d;
            wbl_q     <= wbl_d;
            data_q    <= data_d;
        end
    end

    assign wr_done     = done_q;
    assign BUSY        = busy_q;
    assign WL_ADDR     = addr_q;
    assign WL_EN       = wl_en_q;
    assign PRE         = pre_q;
    assign COL_SEL     = col_sel_q;
    assign WBL         = wbl_q;
    assign WE          = we_q;
    assign ERR_OVERRUN = err_q;

endmodule

// File: tb/tb_dram_wbl_write_seq.sv
// Bench for dram_wbl_write_seq: default-timing and all-ones-timing instances
// compared cycle by cycle against an arithmetic timeline model.
module tb_dram_wbl_write_seq;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        IO_EN = 1'b0;
    logic [5:0]  ADDR = 6'd0;
    logic [63:0] din [16];

    logic        done0, busy0, wl_en0, pre0, we0, err0;
    logic [5:0]  wl_addr0;
    logic [3:0]  col0;
    logic [63:0] wbl0;
    logic        done1, busy1, wl_en1, pre1, we1, err1;
    logic [5:0]  wl_addr1;
    logic [3:0]  col1;
    logic [63:0] wbl1;

    int checks = 0;
    int errors = 0;

    logic [63:0] row_data [16];
    logic [63:0] mem      [64][16];
    logic [63:0] exp_mem  [64][16];

    always #5 CLK = ~CLK;

    dram_wbl_write_seq u_dut0 (
        .CLK(CLK), .RSTn(RSTn), .IO_EN(IO_EN), .ADDR(ADDR),
        .WBL_DATA1(din[0]),   .WBL_DATA2(din[1]),   .WBL_DATA3(din[2]),   .WBL_DATA4(din[3]),
        .WBL_DATA5(din[4]),   .WBL_DATA6(din[5]),   .WBL_DATA7(din[6]),   .WBL_DATA8(din[7]),
        .WBL_DATA9(din[8]),   .WBL_DATA10(din[9]),  .WBL_DATA11(din[10]), .WBL_DATA12(din[11]),
        .WBL_DATA13(din[12]), .WBL_DATA14(din[13]), .WBL_DATA15(din[14]), .WBL_DATA16(din[15]),
        .wr_done(done0), .BUSY(busy0), .WL_ADDR(wl_addr0), .WL_EN(wl_en0), .PRE(pre0),
        .COL_SEL(col0), .WBL(wbl0), .WE(we0), .ERR_OVERRUN(err0)
    );

    dram_wbl_write_seq #(.T_PRE(1), .T_SETUP(1), .T_WE(1), .T_HOLD(1)) u_dut1 (
        .CLK(CLK), .RSTn(RSTn), .IO_EN(IO_EN), .ADDR(ADDR),
        .WBL_DATA1(din[0]),   .WBL_DATA2(din[1]),   .WBL_DATA3(din[2]),   .WBL_DATA4(din[3]),
        .WBL_DATA5(din[4]),   .WBL_DATA6(din[5]),   .WBL_DATA7(din[6]),   .WBL_DATA8(din[7]),
        .WBL_DATA9(din[8]),   .WBL_DATA10(din[9]),  .WBL_DATA11(din[10]), .WBL_DATA12(din[11]),
        .WBL_DATA13(din[12]), .WBL_DATA14(din[13]), .WBL_DATA15(din[14]), .WBL_DATA16(din[15]),
        .wr_done(done1), .BUSY(busy1), .WL_ADDR(wl_addr1), .WL_EN(wl_en1), .PRE(pre1),
        .COL_SEL(col1), .WBL(wbl1), .WE(we1), .ERR_OVERRUN(err1)
    );

    // Macro model: whatever is on the bitlines while WE is high lands in the row.
    always @(negedge CLK) begin
        if (RSTn && we0) mem[wl_addr0][col0] <= wbl0;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Packed view: {ERR, WL_ADDR, PRE, WL_EN, WE, COL_SEL, BUSY, wr_done, WBL}
    function automatic logic [127:0] obs(input int sel);
        if (sel == 0)
            return 128'({err0, wl_addr0, pre0, wl_en0, we0, col0, busy0, done0, wbl0});
        return 128'({err1, wl_addr1, pre1, wl_en1, we1, col1, busy1, done1, wbl1});
    endfunction

    function automatic int row_len(input int sel);
        if (sel == 0) return 2 + 16 * (1 + 2 + 1);
        return 1 + 16 * 3;
    endfunction

    // Expected outputs n cycles after the accepting edge, from the timing rules.
    function automatic logic [127:0] exp_vec(input int sel, input int n, input logic [5:0] a, input logic err);
        int tp, ts, tw, th, tb, k, b, r;
        logic pre, wl, we, busy, done;
        logic [3:0] col;
        logic [63:0] wbl;
        tp = (sel == 0) ? 2 : 1;
        ts = 1;
        tw = (sel == 0) ? 2 : 1;
        th = 1;
        tb = ts + tw + th;
        pre = 0; wl = 0; we = 0; busy = 0; done = 0; col = 0; wbl = 0;
        if (n < tp) begin
            pre = 1; busy = 1;
        end else if (n < tp + 16 * tb) begin
            k = n - tp;
            b = k / tb;
            r = k % tb;
            wl = 1; busy = 1;
            col = 4'(b);
            wbl = row_data[b];
            we = (r >= ts) && (r < ts + tw);
        end else if (n == tp + 16 * tb) begin
            done = 1; busy = 1;
        end
        return 128'({err, a, pre, wl, we, col, busy, done, wbl});
    endfunction

    task automatic rand_inputs();
        ADDR = 6'($urandom);
        for (int k = 0; k < 16; k++) din[k] = {$urandom, $urandom};
    endtask

    // Called at a falling edge; IO_EN is sampled at the following rising edge.
    task automatic run_row(input int sel, input logic [5:0] a, input logic err_in, input int ovr_at,
                           input int abort_at, input bit toggle, input int tail, input string tag);
        int n_end;
        logic err;
        n_end = row_len(sel);
        IO_EN = 1'b1;
        ADDR  = a;
        for (int k = 0; k < 16; k++) din[k] = row_data[k];
        for (int n = 0; n <= n_end + tail; n++) begin
            @(negedge CLK);
            err = err_in || (ovr_at >= 0 && n > ovr_at);
            check(tag, obs(sel), exp_vec(sel, n, a, err));
            IO_EN = (n == ovr_at);
            if (n == ovr_at || (toggle && n < n_end)) rand_inputs();
            if (n == abort_at) begin
                #1 RSTn = 1'b0;
                #1 check("rst_async", obs(sel), 128'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge CLK);
                    check("rst_no_done", obs(sel), 128'd0);
                end
                @(negedge CLK);
                RSTn = 1'b1;
                return;
            end
        end
        IO_EN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 16; k++) din[k] = 64'd0;
        repeat (3) @(negedge CLK);
        check("reset_dut0", obs(0), 128'd0);
        check("reset_dut1", obs(1), 128'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < 16; k++) row_data[k] = 64'(k + 1);
        run_row(0, 6'd5, 1'b0, -1, -1, 1'b0, 1, "row_basic");

        for (int a = 0; a < 64; a++) begin
            for (int k = 0; k < 16; k++) begin
                if (a == 62)      row_data[k] = 64'd0;
                else if (a == 63) row_data[k] = '1;
                else              row_data[k] = {$urandom, $urandom};
                exp_mem[a][k] = row_data[k];
            end
            run_row(0, 6'(a), 1'b0, -1, -1, 1'b0, 1, "row_resp");
        end
        for (int a = 0; a < 64; a++)
            for (int k = 0; k < 16; k++)
                check("macro_row", 128'(mem[a][k]), 128'(exp_mem[a][k]));

        for (int k = 0; k < 16; k++) row_data[k] = {$urandom, $urandom};
        run_row(0, 6'($urandom), 1'b0, 10, -1, 1'b0, 4, "row_overrun");
        for (int k = 0; k < 16; k++) row_data[k] = {$urandom, $urandom};
        run_row(0, 6'($urandom), 1'b1, -1, -1, 1'b0, 1, "row_sticky");

        // Beat 7 first WRITE cycle with default timing: 2 + 7*4 + 1.
        for (int k = 0; k < 16; k++) row_data[k] = {$urandom, $urandom};
        run_row(0, 6'd9, 1'b1, -1, 31, 1'b0, 0, "row_abort");
        for (int k = 0; k < 16; k++) row_data[k] = {$urandom, $urandom};
        run_row(0, 6'd17, 1'b0, -1, -1, 1'b0, 1, "row_after_rst");

        for (int k = 0; k < 16; k++) row_data[k] = {$urandom, $urandom};
        run_row(0, 6'd40, 1'b0, -1, -1, 1'b1, 1, "row_toggle");

        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 16; k++) row_data[k] = {$urandom, $urandom};
        run_row(1, 6'd33, 1'b0, -1, -1, 1'b0, 2, "row_fast");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
